// File: rtl/inst_fetcher.sv
// Instruction fetcher: looks up the I-cache at pc, issues hits downstream,
// fetches misses from memory one word at a time and fills the cache.
//
// Ports
//   clk_in, rst_in (sync, active-high), rdy_in (low = freeze)
//   cache_addr/cache_hit/cache_data : same-cycle cache lookup
//   cache_upd, cache_upd_addr, cache_upd_data : one-cycle fill strobe
//   mem_req, mem_addr, mem_done, mem_data : single outstanding read
//   iq_full : downstream backpressure
//   inst_valid, inst_out, inst_pc : issued instruction
//   redirect, redirect_pc : branch/jump target pulse
module inst_fetcher #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic [31:0] cache_addr,
   input  logic        cache_hit,
   input  logic [31:0] cache_data,
   output logic        cache_upd,
   output logic [31:0] cache_upd_addr,
   output logic [31:0] cache_upd_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   input  logic        iq_full,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      MISS_WAIT = 2'd1,
      DRAIN     = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_out_q, inst_out_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        cache_upd_q, cache_upd_d;
   logic [31:0] cache_upd_addr_q, cache_upd_addr_d;
   logic [31:0] cache_upd_data_q, cache_upd_data_d;

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      inst_valid_d     = 1'b0;
      inst_out_d       = inst_out_q;
      inst_pc_d        = inst_pc_q;
      mem_req_d        = mem_req_q;
      mem_addr_d       = mem_addr_q;
      cache_upd_d      = 1'b0;
      cache_upd_addr_d = cache_upd_addr_q;
      cache_upd_data_d = cache_upd_data_q;

      unique case (state_q)
         FETCH: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end else if (cache_upd_q) begin
               // Fill is being written this cycle; the
               // lookup result is stale, so retry next cycle.
            end else if (!cache_hit) begin
               mem_req_d  = 1'b1;
               mem_addr_d = pc_q;
               state_d    = MISS_WAIT;
            end else if (!iq_full) begin
               inst_valid_d = 1'b1;
               inst_out_d   = cache_data;
               inst_pc_d    = pc_q;
               pc_d         = pc_q + 32'd4;
            end
         end
         MISS_WAIT, DRAIN: begin
            if (mem_done) begin
               mem_req_d        = 1'b0;
               cache_upd_d      = 1'b1;
               cache_upd_addr_d = mem_addr_q;
               cache_upd_data_d = mem_data;
               state_d          = FETCH;
               if (redirect) pc_d = redirect_pc;
            end else if (redirect) begin
               // Request stays in flight; its data still
               // fills the cache but is never issued.
               pc_d    = redirect_pc;
               state_d = DRAIN;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q          <= FETCH;
         pc_q             <= RESET_PC;
         inst_valid_q     <= 1'b0;
         inst_out_q       <= 32'd0;
         inst_pc_q        <= 32'd0;
         mem_req_q        <= 1'b0;
         mem_addr_q       <= 32'd0;
         cache_upd_q      <= 1'b0;
         cache_upd_addr_q <= 32'd0;
         cache_upd_data_q <= 32'd0;
      end else if (rdy_in) begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         inst_valid_q     <= inst_valid_d;
         inst_out_q       <= inst_out_d;
         inst_pc_q        <= inst_pc_d;
         mem_req_q        <= mem_req_d;
         mem_addr_q       <= mem_addr_d;
         cache_upd_q      <= cache_upd_d;
         cache_upd_addr_q <= cache_upd_addr_d;
         cache_upd_data_q <= cache_upd_data_d;
      end
   end

   assign cache_addr     = pc_q;
   assign cache_upd      = cache_upd_q;
   assign cache_upd_addr = cache_upd_addr_q;
   assign cache_upd_data = cache_upd_data_q;
   assign mem_req        = mem_req_q;
   assign mem_addr       = mem_addr_q;
   assign inst_valid     = inst_valid_q;
   assign inst_out       = inst_out_q;
   assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed testbench for inst_fetcher with a one-line fill-tracking
// cache model that misses only at miss_pc until that line is filled.
module tb_inst_fetcher;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic [31:0] cache_addr;
   logic        cache_hit;
   logic [31:0] cache_data;
   logic        cache_upd;
   logic [31:0] cache_upd_addr, cache_upd_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done = 1'b0;
   logic [31:0] mem_data = 32'd0;
   logic        iq_full = 1'b0;
   logic        inst_valid;
   logic [31:0] inst_out, inst_pc;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;

   logic [31:0] miss_pc = 32'h10;
   logic        fill_v = 1'b0;
   logic [31:0] fill_addr = 32'd0;
   logic [31:0] fill_data = 32'd0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   inst_fetcher #(.RESET_PC(32'h0)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
      .cache_addr(cache_addr), .cache_hit(cache_hit),
      .cache_data(cache_data), .cache_upd(cache_upd),
      .cache_upd_addr(cache_upd_addr),
      .cache_upd_data(cache_upd_data),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_done(mem_done), .mem_data(mem_data),
      .iq_full(iq_full), .inst_valid(inst_valid),
      .inst_out(inst_out), .inst_pc(inst_pc),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   wire fill_hit = fill_v && (fill_addr == cache_addr);
   assign cache_hit  = (cache_addr != miss_pc) || fill_hit;
   assign cache_data = fill_hit ? fill_data
                                : (cache_addr ^ 32'hA5A5_0000);

   always @(posedge clk) begin
      if (cache_upd) begin
         fill_v    <= 1'b1;
         fill_addr <= cache_upd_addr;
         fill_data <= cache_upd_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
      tests++; if (inst_out !== 32'd0) begin fails++; $display("FAIL rst_out: got %h want 0", inst_out); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", mem_req); end
      tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL rst_maddr: got %h want 0", mem_addr); end
      tests++; if (cache_upd !== 1'b0) begin fails++; $display("FAIL rst_upd: got %b want 0", cache_upd); end
      tests++; if (cache_addr !== 32'd0) begin fails++; $display("FAIL rst_pc: got %h want 0", cache_addr); end
      rst = 1'b0;
   endtask

   task automatic test_hit_stream();
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL hit_valid[%0d]: got %b want 1", i, inst_valid); end
         tests++; if (inst_pc !== 32'(4 * i)) begin fails++; $display("FAIL hit_pc[%0d]: got %h want %h", i, inst_pc, 32'(4 * i)); end
         tests++; if (inst_out !== (32'(4 * i) ^ 32'hA5A5_0000)) begin fails++; $display("FAIL hit_data[%0d]: got %h want %h", i, inst_out, 32'(4 * i) ^ 32'hA5A5_0000); end
      end
   endtask

   task automatic test_miss();
      tick();
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL miss_req: got %b want 1", mem_req); end
      tests++; if (mem_addr !== 32'h10) begin fails++; $display("FAIL miss_addr: got %h want 10", mem_addr); end
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL miss_noissue: got %b want 0", inst_valid); end
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin fails++; $display("FAIL miss_hold[%0d]: got %b/%h want 1/10", i, mem_req, mem_addr); end
      end
      mem_done = 1'b1;
      mem_data = 32'h0050_0093;
      tick();
      mem_done = 1'b0;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL fill_req: got %b want 0", mem_req); end
      tests++; if (cache_upd !== 1'b1) begin fails++; $display("FAIL fill_upd: got %b want 1", cache_upd); end
      tests++; if (cache_upd_addr !== 32'h10) begin fails++; $display("FAIL fill_addr: got %h want 10", cache_upd_addr); end
      tests++; if (cache_upd_data !== 32'h0050_0093) begin fails++; $display("FAIL fill_data: got %h want 00500093", cache_upd_data); end
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL fill_noissue: got %b want 0", inst_valid); end
      tick();
      tests++; if (cache_upd !== 1'b0) begin fails++; $display("FAIL fill_once: got %b want 0", cache_upd); end
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL lat_m2: got %b want 0", inst_valid); end
      tick();
      tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL lat_m3: got %b want 1", inst_valid); end
      tests++; if (inst_pc !== 32'h10) begin fails++; $display("FAIL miss_pc: got %h want 10", inst_pc); end
      tests++; if (inst_out !== 32'h0050_0093) begin fails++; $display("FAIL miss_out: got %h want 00500093", inst_out); end
   endtask

   task automatic test_backpressure();
      iq_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL bp_valid[%0d]: got %b want 0", i, inst_valid); end
         tests++; if (cache_addr !== 32'h14) begin fails++; $display("FAIL bp_pc[%0d]: got %h want 14", i, cache_addr); end
      end
      iq_full = 1'b0;
      tick();
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h14) begin fails++; $display("FAIL bp_resume: got %b/%h want 1/14", inst_valid, inst_pc); end
      tests++; if (inst_out !== 32'hA5A5_0014) begin fails++; $display("FAIL bp_data: got %h want a5a50014", inst_out); end
   endtask

   task automatic test_redirect_drain();
      miss_pc = 32'h18;
      tick();
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h18) begin fails++; $display("FAIL rd_req: got %b/%h want 1/18", mem_req, mem_addr); end
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      tests++; if (cache_addr !== 32'h200) begin fails++; $display("FAIL rd_pc: got %h want 200", cache_addr); end
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rd_drain_req: got %b want 1", mem_req); end
      for (int i = 0; i < 2; i++) begin
         tick();
         tests++; if (inst_valid !== 1'b0 || mem_req !== 1'b1) begin fails++; $display("FAIL rd_drain[%0d]: got %b/%b want 0/1", i, inst_valid, mem_req); end
      end
      mem_done = 1'b1;
      mem_data = 32'hDEAD_BEEF;
      tick();
      mem_done = 1'b0;
      tests++; if (cache_upd !== 1'b1 || cache_upd_addr !== 32'h18) begin fails++; $display("FAIL rd_fill: got %b/%h want 1/18", cache_upd, cache_upd_addr); end
      tests++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL rd_done: got %b/%b want 0/0", mem_req, inst_valid); end
      tick();
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rd_noold: got %b want 0", inst_valid); end
      tick();
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin fails++; $display("FAIL rd_newpc: got %b/%h want 1/200", inst_valid, inst_pc); end
      tests++; if (inst_out !== 32'hA5A5_0200) begin fails++; $display("FAIL rd_newdata: got %h want a5a50200", inst_out); end
   endtask

   task automatic test_redirect_hit();
      redirect = 1'b1;
      redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rh_discard: got %b want 0", inst_valid); end
      tests++; if (cache_addr !== 32'h300) begin fails++; $display("FAIL rh_pc: got %h want 300", cache_addr); end
      tick();
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin fails++; $display("FAIL rh_issue: got %b/%h want 1/300", inst_valid, inst_pc); end
   endtask

   task automatic test_stall_reset();
      miss_pc = 32'h304;
      tick();
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin fails++; $display("FAIL st_req: got %b/%h want 1/304", mem_req, mem_addr); end
      rdy = 1'b0;
      mem_done = 1'b1;
      mem_data = 32'h1234_5678;
      redirect = 1'b1;
      redirect_pc = 32'h400;
      for (int i = 0; i < 3; i++) begin
         tick();
         mem_done = 1'b0;
         redirect = 1'b0;
         tests++; if (mem_req !== 1'b1 || cache_upd !== 1'b0) begin fails++; $display("FAIL st_hold[%0d]: got %b/%b want 1/0", i, mem_req, cache_upd); end
         tests++; if (cache_addr !== 32'h304) begin fails++; $display("FAIL st_pc[%0d]: got %h want 304", i, cache_addr); end
      end
      rdy = 1'b1;
      tick();
      tests++; if (mem_req !== 1'b1 || cache_upd !== 1'b0) begin fails++; $display("FAIL st_after: got %b/%b want 1/0", mem_req, cache_upd); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mr_req: got %b want 0", mem_req); end
      tests++; if (cache_addr !== 32'h0) begin fails++; $display("FAIL mr_pc: got %h want 0", cache_addr); end
      mem_done = 1'b1;
      mem_data = 32'hFFFF_FFFF;
      tick();
      mem_done = 1'b0;
      tests++; if (cache_upd !== 1'b0) begin fails++; $display("FAIL mr_stale: got %b want 0", cache_upd); end
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin fails++; $display("FAIL mr_issue: got %b/%h want 1/0", inst_valid, inst_pc); end
   endtask

   initial begin
      test_reset();
      test_hit_stream();
      test_miss();
      test_backpressure();
      test_redirect_drain();
      test_redirect_hit();
      test_stall_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
